// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-by-word block copier that drives the data-memory port.
// A copy alternates READ (fetch one word into a hold register) and WRITE
// (store it at the destination), so every word costs exactly two cycles.
// All memory-port outputs are decoded from registered state; nothing in the
// output path depends combinationally on start.
module mem_copy_engine #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic [31:0]      dir,
  output logic [31:0]      data_input,
  output logic             mem_rd,
  output logic             mem_wd,
  input  logic [31:0]      data_output,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_left
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] WORD_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [31:0]      hold;
  logic [LEN_W-1:0] count;
  logic             accept;

  // A request is taken only while idle; requests during a copy are dropped.
  assign accept = (state == IDLE) && start;

  // State register; reset aborts any copy in flight on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: READ/WRITE alternate until the last word is stored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? DONE : READ;
        end
      end
      READ:  state_next = WRITE;
      WRITE: state_next = (count == LEN_W'(1)) ? DONE : READ;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Remaining-word counter; it is visible on a port, so it is cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (accept) begin
      count <= len;
    end else if (state == WRITE) begin
      count <= count - LEN_W'(1);
    end
  end

  // Address pointers and hold register; only observed through state-gated
  // outputs, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      src_ptr <= src_addr & WORD_MASK;
      dst_ptr <= dst_addr & WORD_MASK;
    end else if (state == WRITE) begin
      src_ptr <= src_ptr + WORD_STEP;
      dst_ptr <= dst_ptr + WORD_STEP;
    end
    if (state == READ) begin
      hold <= data_output;
    end
  end

  // Memory-port and status decode from the registered state.
  always_comb begin
    dir        = '0;
    data_input = '0;
    mem_rd     = 1'b0;
    mem_wd     = 1'b0;
    case (state)
      READ: begin
        dir    = src_ptr;
        mem_rd = 1'b1;
      end
      WRITE: begin
        dir        = dst_ptr;
        data_input = hold;
        mem_wd     = 1'b1;
      end
      default: begin
        dir        = '0;
        data_input = '0;
      end
    endcase
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign words_left = count;

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Block-copy engine acting as the initiator on the data-memory port (`dir` / `data_input` / `mem_rd` / `mem_wd` / `data_output`). On a start pulse it reads `len` consecutive 32-bit words from a source address and writes them to a destination address, one word at a time. It sits between the control logic and the data memory, occupying the memory port only while busy. It is the master-side counterpart of the data memory.

## Interface
Parameters:
- `LEN_W`, 16, width of the word-count input and progress counter.

Ports:
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `rst_n`, in, 1, reset, synchronous and active-low.
- `start`, in, 1, request a copy; sampled only in IDLE.
- `src_addr`, in, 32, source byte address; bits [1:0] ignored.
- `dst_addr`, in, 32, destination byte address; bits [1:0] ignored.
- `len`, in, LEN_W, number of words to copy.
- `dir`, out, 32, memory address.
- `data_input`, out, 32, write data driven to the memory.
- `mem_rd`, out, 1, memory read enable.
- `mem_wd`, out, 1, memory write enable.
- `data_output`, in, 32, read data returned by the memory.
- `busy`, out, 1, high from the cycle after `start` is accepted until DONE ends.
- `done`, out, 1, one-cycle pulse when the copy completes.
- `words_left`, out, LEN_W, number of words not yet written.

## Operation
- States are IDLE, READ, WRITE and DONE. The state and all outputs are registered or decoded from registered state. There are no combinational paths from `start`.
- **IDLE:**
  - If `start` = 1, latch `src_addr & ~3`, `dst_addr & ~3` and `len`.
  - If `len` = 0, go to DONE. Otherwise go to READ.
- **READ:**
  - Drive `dir` = src pointer and `mem_rd` = 1.
  - At the clock edge, capture `data_output` into a 32-bit hold register and go to WRITE.
  - The memory read is combinational: data is valid within the same cycle that `mem_rd` and `dir` are stable.
- **WRITE:**
  - Drive `dir` = dst pointer, `data_input` = hold register and `mem_wd` = 1. The memory writes on this edge.
  - At the edge, both pointers advance by 4 (modulo 2^32, wrap-around allowed) and `words_left` decrements.
  - If `words_left` was 1, go to DONE. Otherwise go to READ.
- **DONE:** assert `done` = 1 for exactly one cycle, then go to IDLE.
- `mem_rd` and `mem_wd` are never high in the same cycle. Both are 0 in IDLE and DONE.
- `dir` = 0 and `data_input` = 0 whenever not in READ or WRITE.
- `start` while busy (READ, WRITE or DONE) is ignored. It is not queued.
- Overlapping regions are copied forward, word by word, with no overlap detection. When dst = src+4, the first word propagates through the whole region.
- **Reset:**
  - `rst_n` = 0 at any edge forces IDLE on that edge.
  - All outputs return to 0 (`dir`, `data_input`, `mem_rd`, `mem_wd`, `busy`, `done`, `words_left`).
  - A reset during a copy aborts it. No further writes are issued, and words already written remain in memory.

## Timing
- The edge that samples `start` is E0. After E0 the state is READ.
- Each word takes 2 cycles: READ then WRITE.
- For `len` = N ≥ 1:
  - the memory write of word k (k = 0..N-1) occurs at edge E0+2k+2;
  - `done` is high during the cycle following edge E0+2N;
  - the engine is back in IDLE and accepts a new `start` at edge E0+2N+1.
- For `len` = 0: `done` is high in the cycle after E0, and `busy` is high for that single cycle.
- `busy` is high in READ, WRITE and DONE.
- `words_left` updates at each WRITE edge and reads 0 during DONE.

## Test plan
- **Reset.** Hold `rst_n` = 0 for 3 cycles with `start` = 1 → all outputs 0, state IDLE, no memory access.
- **Basic copy.**
  - Preload 0x400000..0x40000C with 1802, 2703, 707, 1818.
  - `start` with src = 0x400000, dst = 0x400100, len = 4.
  - Expected: 0x400100..0x40010C read back 1802, 2703, 707, 1818; `done` pulses at E0+9; `mem_rd`/`mem_wd` alternate and never overlap.
- **Zero length.** `len` = 0 → `done` in the cycle after E0, no `mem_rd` or `mem_wd` asserted.
- **Unaligned addresses, start while busy.**
  - src = 0x400003, dst = 0x400101, len = 1 → accesses go to 0x400000 and 0x400100.
  - Pulse `start` again mid-copy → it is ignored, and exactly one `done` pulse is produced.
- **Reset mid-copy.**
  - len = 4; drop `rst_n` at E0+5.
  - Expected: only words 0 and 1 are written; outputs are 0 from the next cycle; a later `start` runs a fresh copy correctly.
- **Overlap and wrap-around.**
  - Overlap: src = 0x400000, dst = 0x400004, len = 3 with preload {1802, 2703, 707, 1818} → memory becomes {1802, 1802, 1802, 1802}.
  - Wrap-around: src = 0xFFFFFFFC, len = 2 → second read at 0x00000000.
